// File: rtl/md_sequencer.sv
// Multi-cycle signed multiply/divide sequencer for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, with a sign fix-up cycle.
module md_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             divByZero
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] OpMul = 2'b01;
  localparam logic [1:0] OpDiv = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;

  logic               start_acc;
  logic [WIDTH-1:0]   abs_a, abs_b, acc_hi, addend;
  logic [WIDTH:0]     mul_sum, trial;
  logic [WIDTH-1:0]   rem_sh, rem_nx, quot_sh, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign start_acc = start & ((op == OpMul) | (op == OpDiv)) &
                     ((state_q == StIdle) | (state_q == StDone)) & ~abort;

  // Magnitudes fit WIDTH bits unsigned, including |most-negative|.
  assign abs_a  = opA[WIDTH-1] ? -opA : opA;
  assign abs_b  = opB[WIDTH-1] ? -opB : opB;
  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];

  assign addend  = mag_b_q[0] ? mag_a_q : '0;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, addend};

  // Remainder stays below the divisor, so the shifted remainder never overflows WIDTH bits;
  // for divide the dividend register shifts out into rem and collects quotient bits.
  assign rem_sh  = {acc_hi[WIDTH-2:0], mag_a_q[WIDTH-1]};
  assign trial   = {1'b0, rem_sh} - {1'b0, mag_b_q};
  assign quot_sh = {mag_a_q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_nx  = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];

  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign quot_fix = negq_q ? -mag_a_q : mag_a_q;
  assign rem_fix  = negr_q ? -acc_hi : acc_hi;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    if (abort) begin
      state_d = StIdle;
    end else if (start_acc) begin
      op_d    = op;
      count_d = '0;
      acc_d   = '0;
      mag_a_d = abs_a;
      mag_b_d = abs_b;
      negq_d  = opA[WIDTH-1] ^ opB[WIDTH-1];
      negr_d  = opA[WIDTH-1];
      dbz_d   = 1'b0;
      if ((op == OpDiv) && (opB == '0)) begin
        state_d  = StDone;
        res_lo_d = '1;
        res_hi_d = opA;
        dbz_d    = 1'b1;
      end else begin
        state_d = StCalc;
      end
    end else begin
      case (state_q)
        StCalc: begin
          count_d = count_q + CntW'(1);
          if (op_q == OpMul) begin
            acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
            mag_b_d = mag_b_q >> 1;
          end else begin
            acc_d   = {rem_nx, acc_q[WIDTH-1:0]};
            mag_a_d = quot_sh;
          end
          if (count_q == LastCnt) state_d = StFix;
        end
        StFix: begin
          if (op_q == OpMul) begin
            res_lo_d = prod_fix[WIDTH-1:0];
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end else begin
            res_lo_d = quot_fix;
            res_hi_d = rem_fix;
          end
          state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      count_q  <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q == StCalc) | (state_q == StFix);
  assign stall     = busy | start_acc;
  assign done      = (state_q == StDone);
  assign resultLo  = res_lo_q;
  assign resultHi  = res_hi_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: per-cycle comparison against a transaction-level model
// plus directed cases with hand-computed results.
module tb_md_sequencer;

  localparam int unsigned WIDTH = 16;

  logic             clk, reset, start, abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA, opB;
  logic             busy, stall, done, divByZero;
  logic [WIDTH-1:0] resultLo, resultHi;

  md_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
    .opA(opA), .opB(opB), .busy(busy), .stall(stall), .done(done),
    .resultLo(resultLo), .resultHi(resultHi), .divByZero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stall_cnt;

  // Model: cycles of work left, done flag, visible and pending results.
  int          m_left = 0;
  bit          m_done = 0;
  bit          m_dbz  = 0;
  logic [15:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;

  // Last sampled DUT outputs.
  logic        s_busy, s_stall, s_done, s_dbz;
  logic [15:0] s_lo, s_hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic void model_calc(input logic [1:0] o, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] lo,
                                     output logic [15:0] hi);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b01) begin
      p  = sa * sb;
      lo = p[15:0];
      hi = p[31:16];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[15:0];
      hi = r[15:0];
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare just before the rising
  // edge, then advance the model across that edge.
  task automatic cycle(input bit st, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input bit ab);
    bit m_busy, acc;
    @(negedge clk);
    start = st; op = o; opA = a; opB = b; abort = ab;
    #4;
    s_busy = busy; s_stall = stall; s_done = done;
    s_lo = resultLo; s_hi = resultHi; s_dbz = divByZero;
    if (s_stall) stall_cnt++;
    m_busy = (m_left > 0);
    acc    = st && (o == 2'b01 || o == 2'b10) && !m_busy && !ab;
    chk("busy", s_busy, m_busy);
    chk("stall", s_stall, m_busy || acc);
    chk("done", s_done, m_done);
    chk("resultLo", s_lo, m_lo);
    chk("resultHi", s_hi, m_hi);
    chk("divByZero", s_dbz, m_dbz);
    if (ab) begin
      m_left = 0;
      m_done = 0;
    end else if (acc) begin
      if (o == 2'b10 && b == 16'h0000) begin
        m_lo = 16'hFFFF; m_hi = a; m_dbz = 1; m_done = 1; m_left = 0;
      end else begin
        model_calc(o, a, b, p_lo, p_hi);
        m_dbz = 0; m_done = 0; m_left = WIDTH + 1;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_lo = p_lo; m_hi = p_hi; m_done = 1;
      end else begin
        m_done = 0;
      end
    end else begin
      m_done = 0;
    end
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Issue an operation and wait (bounded) for done; lat is -1 if it never came.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    stall_cnt = 0;
    cycle(1'b1, o, a, b, 1'b0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (s_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pin(input string name, input logic [1:0] o, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] lo, input logic [15:0] hi);
    int lat;
    do_op(o, a, b, lat);
    chk({name, "_latency"}, lat, 18);
    chk({name, "_lo"}, s_lo, lo);
    chk({name, "_hi"}, s_hi, hi);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h0001;
      4:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    start = 0; op = 2'b00; abort = 0; opA = '0; opB = '0;
    reset = 1'b1;
    #3;
    chk("reset_busy", busy, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_lo", resultLo, 16'h0000);
    chk("reset_hi", resultHi, 16'h0000);
    chk("reset_dbz", divByZero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    do_op(2'b01, 16'h0003, 16'hFFFC, lat);
    chk("mul3x-4_latency", lat, 18);
    chk("mul3x-4_stall_cycles", stall_cnt, 18);
    chk("mul3x-4_lo", s_lo, 16'hFFF4);
    chk("mul3x-4_hi", s_hi, 16'hFFFF);
    pin("mul7fff", 2'b01, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF);
    pin("mul8000", 2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000);
    pin("div-7by2", 2'b10, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF);
    pin("div100by7", 2'b10, 16'd100, 16'd7, 16'd14, 16'd2);
    pin("div8000byffff", 2'b10, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);

    do_op(2'b10, 16'h1234, 16'h0000, lat);
    chk("div0_latency", lat, 1);
    chk("div0_stall_cycles", stall_cnt, 1);
    chk("div0_flag", s_dbz, 1'b1);
    chk("div0_lo", s_lo, 16'hFFFF);
    chk("div0_hi", s_hi, 16'h1234);
    pin("mul2x3", 2'b01, 16'd2, 16'd3, 16'd6, 16'd0);
    chk("div0_flag_cleared", s_dbz, 1'b0);

    // Non-operations do not stall.
    cycle(1'b1, 2'b00, 16'h0005, 16'h0006, 1'b0);
    chk("op00_no_stall", s_stall, 1'b0);
    cycle(1'b1, 2'b11, 16'h0005, 16'h0006, 1'b0);
    chk("op11_no_stall", s_stall, 1'b0);
    idle();

    // Start during CALC is ignored.
    stall_cnt = 0;
    cycle(1'b1, 2'b01, 16'd5, 16'd6, 1'b0);
    for (int i = 1; i < 5; i++) idle();
    cycle(1'b1, 2'b10, 16'd9, 16'd3, 1'b0);
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      idle();
      if (s_done) begin
        lat = i;
        break;
      end
    end
    chk("ignored_start_latency", lat, 18);
    chk("ignored_start_lo", s_lo, 16'd30);

    // Back-to-back: start in the DONE cycle.
    cycle(1'b1, 2'b01, 16'd7, 16'd8, 1'b0);
    for (int i = 1; i < 18; i++) idle();
    cycle(1'b1, 2'b10, 16'd50, 16'd6, 1'b0);
    chk("b2b_done_in_done", s_done, 1'b1);
    chk("b2b_stall_in_done", s_stall, 1'b1);
    chk("b2b_old_result", s_lo, 16'd56);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (s_done) begin
        lat = i;
        break;
      end
    end
    chk("b2b_latency", lat, 18);
    chk("b2b_lo", s_lo, 16'd8);
    chk("b2b_hi", s_hi, 16'd2);

    // Abort at cycle 8 keeps previous results.
    cycle(1'b1, 2'b01, 16'd11, 16'd13, 1'b0);
    for (int i = 1; i < 8; i++) idle();
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1);
    idle();
    chk("abort_busy", s_busy, 1'b0);
    chk("abort_stall", s_stall, 1'b0);
    chk("abort_keep_lo", s_lo, 16'd8);
    chk("abort_keep_hi", s_hi, 16'd2);
    for (int i = 0; i < 20; i++) idle();

    // Async reset at cycle 8 of a multiply.
    cycle(1'b1, 2'b01, 16'd11, 16'd13, 1'b0);
    for (int i = 1; i < 8; i++) idle();
    @(negedge clk);
    start = 0; op = 2'b00; abort = 0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_stall", stall, 1'b0);
    chk("async_reset_done", done, 1'b0);
    chk("async_reset_lo", resultLo, 16'h0000);
    chk("async_reset_hi", resultHi, 16'h0000);
    chk("async_reset_dbz", divByZero, 1'b0);
    m_left = 0; m_done = 0; m_dbz = 0; m_lo = '0; m_hi = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          st, ab;
      logic [1:0]  o;
      int          r;
      st = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 19);
      o  = (r < 9) ? 2'b01 : (r < 18) ? 2'b10 : (r == 18) ? 2'b00 : 2'b11;
      ab = ($urandom_range(0, 59) == 0);
      cycle(st, o, pick_val(), pick_val(), ab);
    end
    for (int i = 0; i < 20; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
